// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the modulo step counter family.
// Holds the RUN/HALT encoding, direction constants and a width check.
package mod_counter_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  function automatic bit width_ok(
    input int     bit_sz,
    input longint modulus
  );
    return (modulus >= 2) &&
           (modulus <= (longint'(1) << bit_sz));
  endfunction

endpackage

// File: rtl/mod_add_sub.sv
// Modulo add/subtract of a step, returning the next count and a wrap flag.
// Shared with the dual-pointer address generator.
module mod_add_sub
  import mod_counter_pkg::*;
#(
  parameter int BIT_SZ  = 13,
  parameter int MODULUS = 8192
) (
  input  logic [BIT_SZ-1:0] count_i,
  input  logic [BIT_SZ-1:0] step_i,
  input  logic              dir_i,
  output logic [BIT_SZ-1:0] next_o,
  output logic              wrap_o
);

  localparam logic [BIT_SZ:0] MOD_W =
    (BIT_SZ+1)'(MODULUS);

  logic [BIT_SZ:0] cnt_w;
  logic [BIT_SZ:0] stp_w;
  logic [BIT_SZ:0] res_w;

  assign cnt_w = {1'b0, count_i};
  assign stp_w = {1'b0, step_i};

  always_comb begin
    res_w  = cnt_w;
    wrap_o = 1'b0;
    if (dir_i == DIR_UP) begin
      res_w = cnt_w + stp_w;
      if (res_w >= MOD_W) begin
        res_w  = res_w - MOD_W;
        wrap_o = 1'b1;
      end
    end else if (cnt_w >= stp_w) begin
      res_w = cnt_w - stp_w;
    end else begin
      // cnt < step <= MODULUS keeps this below MODULUS
      res_w  = cnt_w + MOD_W - stp_w;
      wrap_o = 1'b1;
    end
  end

  assign next_o = res_w[BIT_SZ-1:0];

endmodule

// File: rtl/mod_step_counter.sv
// Modulo-N up/down step counter with load, tc pulse and one-shot halt.
// Optional wrap_cnt output under MOD_STEP_COUNTER_WRAP_CNT_EN.
module mod_step_counter
  import mod_counter_pkg::*;
#(
  parameter int BIT_SZ    = 13,
  parameter int MODULUS   = 8192,
  parameter int RESET_VAL = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              dir,
  input  logic [BIT_SZ-1:0] step,
  input  logic              load,
  input  logic [BIT_SZ-1:0] load_val,
  input  logic              one_shot,
  output logic [BIT_SZ-1:0] count,
  output logic              tc,
  output logic              halted
`ifdef MOD_STEP_COUNTER_WRAP_CNT_EN
  ,
  output logic [7:0]        wrap_cnt
`endif
);

  localparam logic [BIT_SZ:0] MOD_W =
    (BIT_SZ+1)'(MODULUS);
  localparam logic [BIT_SZ-1:0] MAX_V =
    BIT_SZ'(MODULUS - 1);
  localparam logic [BIT_SZ-1:0] RST_V =
    BIT_SZ'(RESET_VAL);

  generate
    if (!width_ok(BIT_SZ, MODULUS) ||
        RESET_VAL >= MODULUS) begin : g_bad
      $error("mod_step_counter: bad params");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [BIT_SZ-1:0] count_q, count_d;
  logic              tc_q, tc_d;
  logic              halted_q;
  logic [BIT_SZ-1:0] nxt;
  logic              wrap;

  mod_add_sub #(
    .BIT_SZ (BIT_SZ),
    .MODULUS(MODULUS)
  ) u_add_sub (
    .count_i(count_q),
    .step_i (step),
    .dir_i  (dir),
    .next_o (nxt),
    .wrap_o (wrap)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = ({1'b0, load_val} < MOD_W) ?
                load_val : MAX_V;
      state_d = RUN;
    end else if (enable && state_q == RUN) begin
      count_d = nxt;
      tc_d    = wrap;
      if (wrap && one_shot) state_d = HALT;
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      count_q  <= RST_V;
      tc_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      tc_q     <= tc_d;
      halted_q <= (state_d == HALT);
    end
  end

  assign count  = count_q;
  assign tc     = tc_q;
  assign halted = halted_q;

`ifdef MOD_STEP_COUNTER_WRAP_CNT_EN
  logic [7:0] wrap_cnt_q;

  // Saturating pass counter for the echo block
  always_ff @(negedge clock) begin
    if (reset || load) begin
      wrap_cnt_q <= 8'd0;
    end else if (tc_d && wrap_cnt_q != 8'hFF) begin
      wrap_cnt_q <= wrap_cnt_q + 8'd1;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

  a_step_range : assert property (
    @(negedge clock) disable iff (reset)
    (enable && !load) |->
      ({1'b0, step} <= MOD_W)
  );

endmodule

// File: tb/tb_mod_step_counter.sv
// Scoreboard bench for mod_step_counter (MODULUS 10).
// Directed plan sequences then randomized traffic against an integer model.
module tb_mod_step_counter;

  localparam int BW = 5;
  localparam int M  = 10;
  localparam int RV = 0;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          dir = 1'b0;
  logic [BW-1:0] step = '0;
  logic          load = 1'b0;
  logic [BW-1:0] load_val = '0;
  logic          one_shot = 1'b0;
  logic [BW-1:0] count;
  logic          tc;
  logic          halted;
`ifdef MOD_STEP_COUNTER_WRAP_CNT_EN
  logic [7:0]    wrap_cnt;
`endif

  mod_step_counter #(
    .BIT_SZ   (BW),
    .MODULUS  (M),
    .RESET_VAL(RV)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .dir     (dir),
    .step    (step),
    .load    (load),
    .load_val(load_val),
    .one_shot(one_shot),
    .count   (count),
    .tc      (tc),
    .halted  (halted)
`ifdef MOD_STEP_COUNTER_WRAP_CNT_EN
    ,
    .wrap_cnt(wrap_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int cnt;
    bit tc;
    bit halt;
    int wc;
    int seq;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   seq = 0;

  int m_cnt = 0;
  bit m_tc = 0;
  bit m_halt = 0;
  int m_wc = 0;

  task automatic cyc(
    input bit r, input bit ld, input bit en,
    input bit d, input bit os,
    input int st, input int lv
  );
    int n;
    exp_t e;
    @(posedge clock);
    reset    = r;
    load     = ld;
    enable   = en;
    dir      = d;
    one_shot = os;
    step     = BW'(st);
    load_val = BW'(lv);
    m_tc = 0;
    if (r) begin
      m_cnt = RV; m_halt = 0; m_wc = 0;
    end else if (ld) begin
      m_cnt = (lv < M) ? lv : M - 1;
      m_halt = 0; m_wc = 0;
    end else if (en && !m_halt) begin
      n = d ? m_cnt - st : m_cnt + st;
      m_tc = (n < 0) || (n >= M);
      m_cnt = (n + M) % M;
      if (m_tc && os) m_halt = 1;
      if (m_tc && m_wc < 255) m_wc++;
    end
    e.cnt = m_cnt; e.tc = m_tc;
    e.halt = m_halt; e.wc = m_wc;
    e.seq = seq++;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int s,
                     input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s[#%0d] got %0d expected %0d",
               nm, s, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count", e.seq, int'(count), e.cnt);
        chk("tc", e.seq, int'(tc), int'(e.tc));
        chk("halted", e.seq, int'(halted), int'(e.halt));
`ifdef MOD_STEP_COUNTER_WRAP_CNT_EN
        chk("wrap_cnt", e.seq, int'(wrap_cnt), e.wc);
`endif
      end
    end
  end

  initial begin : stim
    // reset with enable low, then count 1,2,3
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 1, 0, 0, 1, 0);
    // up wrap: 3,6,9,2
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 1, 0, 0, 3, 0);
    // down wrap: 7,3,9
    cyc(0, 1, 0, 1, 0, 0, 1);
    repeat (3) cyc(0, 0, 1, 1, 0, 4, 0);
    // one-shot halt, ignored enables, load restarts
    cyc(0, 1, 0, 0, 1, 0, 8);
    cyc(0, 0, 1, 0, 1, 2, 0);
    repeat (3) cyc(0, 0, 1, 0, 1, 2, 0);
    repeat (2) cyc(0, 0, 1, 1, 0, 3, 0);
    cyc(0, 1, 0, 0, 0, 0, 3);
    // clamp, load over enable, reset over load
    cyc(0, 1, 1, 0, 0, 1, 15);
    cyc(1, 1, 1, 0, 0, 1, 15);
    // step == MODULUS and step 0 boundaries
    cyc(0, 1, 0, 0, 0, 0, 9);
    cyc(0, 0, 1, 0, 0, M, 0);
    cyc(0, 0, 1, 1, 0, M, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, M, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(31) == 0),
          ($urandom_range(9) == 0),
          ($urandom_range(3) != 0),
          1'($urandom_range(1)),
          ($urandom_range(3) == 0),
          int'($urandom_range(M)),
          int'($urandom_range((1 << BW) - 1)));
    end
`ifdef MOD_STEP_COUNTER_WRAP_CNT_EN
    cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (2600) cyc(0, 0, 1, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 2);
`endif
    @(negedge clock);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending expected 0",
               q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
